serial_frame_sched: RTL and testbench
=====================================

SERIAL_FRAME_SCHED -- requirements
Module: serial_frame_sched

Interface
REQ-001 Parameters SHALL be: N_REQ, default 4, number of requesters; CMD_W, default 7, command bits per frame; RSP_W, default 10, response bits per frame; FRAME_LEN, default 40, cycles per frame.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  N_REQ  per-requester frame request, level; held until granted.
REQ-005 req_cmd  input  N_REQ*CMD_W  per-requester command; slice i = bits [i*CMD_W +: CMD_W].
REQ-006 gnt  output  N_REQ  one-hot grant pulse, one cycle long.
REQ-007 count40  output  6  frame cycle counter, drives interface FSM.
REQ-008 dq_en  input  1  write-phase tristate enable from interface FSM.
REQ-009 sr_en  input  1  shift enable from interface FSM.
REQ-010 dq_out  output  1  serial command bit, MSB first.
REQ-011 dq_in  input  1  serial response bit.
REQ-012 rsp_valid  output  1  response pulse, one cycle long.
REQ-013 rsp_id  output  $clog2(N_REQ)  index of the requester owning the response.
REQ-014 rsp_data  output  RSP_W  captured response, first received bit in the MSB.
REQ-015 rsp_err  output  1  bit-count mismatch, qualified by rsp_valid.
REQ-016 busy  output  1  high while the current frame is active (granted).

Function
REQ-017 count40 SHALL free-run 0..FRAME_LEN-1 and wrap from 39 to 0, incrementing every cycle.
REQ-018 On the edge where count40==39, the block SHALL sample req and select a winner round-robin, with the highest priority going to the index after the last winner.
REQ-019 After reset, the last winner SHALL be N_REQ-1, so requester 0 has first priority.
REQ-020 The winner's gnt bit SHALL be high for exactly the cycle in which count40==0, and its command SHALL load into the TX shift register on the same edge.
REQ-021 If req is all zero at sampling, the frame SHALL be idle: the TX register loads zero, busy stays 0, no gnt is issued, and no rsp_valid is generated.
REQ-022 A req that rises after the count40==39 edge SHALL wait for the next frame; a req that drops before sampling SHALL be ignored.
REQ-023 dq_out SHALL equal the TX register MSB combinationally.
REQ-024 TX SHALL shift left, filling with 0, on each edge with sr_en=1 and dq_en=1; the TX bit counter SHALL increment on each such edge.
REQ-025 RX SHALL shift in dq_in at the LSB on each edge with sr_en=1 and dq_en=0; the RX bit counter SHALL increment on each such edge, saturating at 15.
REQ-026 Both bit counters and the RX register SHALL clear on the frame-load edge (count40 39->0).
REQ-027 Frame FSM states SHALL be IDLE_FRM, ACTIVE_FRM and REPORT.
- IDLE_FRM -> ACTIVE_FRM on the load edge with a winner.
- ACTIVE_FRM -> REPORT on the edge where count40==36.
- REPORT -> IDLE_FRM after one cycle, or -> ACTIVE_FRM if REPORT coincides with a load edge that has a winner.
REQ-028 rsp_valid SHALL be high only in REPORT, which is the cycle count40==37, with rsp_id set to the latched winner and rsp_data set to RX.
REQ-029 rsp_err SHALL be 1 when the TX count != CMD_W or the RX count != RSP_W.
REQ-030 busy SHALL be 1 in ACTIVE_FRM and REPORT.
REQ-031 sr_en/dq_en activity in IDLE_FRM SHALL shift the registers but SHALL NOT produce a response.

Reset
REQ-032 On rst_n low the block SHALL set: count40=0, state=IDLE_FRM, gnt=0, rsp_valid=0, rsp_err=0, rsp_id=0, rsp_data=0, busy=0, TX=0 (so dq_out=0), RX=0, bit counters=0, and last winner=N_REQ-1.
REQ-033 Reset asserted mid-frame SHALL abort the frame with no rsp_valid; after release the next grant SHALL occur at the first count40 39->0 transition.

Structure
REQ-034 A shared package serial_if_pkg SHALL hold FRAME_LEN, CMD_W, RSP_W, the frame-state enum, and the sampling/report count constants (39, 36, 37).
REQ-035 The round-robin selection SHALL be a sub-module rr_arbiter (req, advance, grant one-hot, last-winner register).

Verification
REQ-036 Single request: req=0001, cmd0=7'b1011001, interface FSM connected, dq_in driving 10'b1100110101 -> gnt=0001 at count40=0; dq_out sequence 1,0,1,1,0,0,1; rsp_valid at count40=37 with rsp_id=0, rsp_data=10'h335, rsp_err=0.
REQ-037 Contention: req=1111 held across 4 frames -> grant order 0,1,2,3, then 0 on the fifth frame.
REQ-038 Idle frame: req=0000 across the 39 boundary -> gnt=0, busy=0, no rsp_valid while count40 keeps wrapping 39->0.
REQ-039 Late request: req2 rising at count40=39+1 cycle -> no grant until the following frame's count40=0.
REQ-040 Error: suppress one sr_en pulse in the read phase -> rsp_valid with rsp_err=1.
REQ-041 Reset at count40=20 in ACTIVE_FRM -> outputs return to their reset values immediately, and no rsp_valid is produced for the aborted frame.

Source files
------------

// File: rtl/serial_if_pkg.sv
// Shared constants and frame-state type for the serial frame scheduler.
package serial_if_pkg;

  localparam int N_REQ     = 4;
  localparam int CMD_W     = 7;
  localparam int RSP_W     = 10;
  localparam int FRAME_LEN = 40;

  // Frame-relative markers: arbitration/load, end of active window, report cycle
  localparam int SAMPLE_CNT  = 39;
  localparam int ACT_END_CNT = 36;
  localparam int REPORT_CNT  = 37;

  typedef enum logic [1:0] {
    IDLE_FRM,
    ACTIVE_FRM,
    REPORT
  } frame_state_t;

  function automatic logic [5:0] cnt_next(input logic [5:0] cnt, input int len);
    return (int'(cnt) >= len - 1) ? 6'd0 : cnt + 6'd1;
  endfunction

endpackage

// File: rtl/serial_frame_sched_if.sv
// Requester and serial-link signals of the frame scheduler.
interface serial_frame_sched_if #(
  parameter int N_REQ = serial_if_pkg::N_REQ,
  parameter int CMD_W = serial_if_pkg::CMD_W,
  parameter int RSP_W = serial_if_pkg::RSP_W
) ();
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       req;
  logic [N_REQ*CMD_W-1:0] req_cmd;
  logic [N_REQ-1:0]       gnt;
  logic [5:0]             count40;
  logic                   dq_en;
  logic                   sr_en;
  logic                   dq_out;
  logic                   dq_in;
  logic                   rsp_valid;
  logic [ID_W-1:0]        rsp_id;
  logic [RSP_W-1:0]       rsp_data;
  logic                   rsp_err;
  logic                   busy;

  modport slave (
    input  req, req_cmd, dq_en, sr_en, dq_in,
    output gnt, count40, dq_out, rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

  modport master (
    output req, req_cmd, dq_en, sr_en, dq_in,
    input  gnt, count40, dq_out, rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the index after the last winner has top priority.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  last
);
  logic [ID_W-1:0] win_idx;
  logic [ID_W-1:0] idx;
  logic            found;

  always_comb begin
    grant   = '0;
    win_idx = last;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = ID_W'((int'(last) + k) % N_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        win_idx    = idx;
        found      = 1'b1;
      end
    end
  end

  // Reset value makes requester 0 the first in line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                last <= ID_W'(N_REQ - 1);
    else if (advance && found) last <= win_idx;
  end
endmodule

// File: rtl/serial_frame_sched.sv
// Frame-based serial scheduler: one arbitration per frame, shifts the winner's
// command out MSB first and reports the captured response near frame end.
module serial_frame_sched #(
  parameter int N_REQ     = serial_if_pkg::N_REQ,
  parameter int CMD_W     = serial_if_pkg::CMD_W,
  parameter int RSP_W     = serial_if_pkg::RSP_W,
  parameter int FRAME_LEN = serial_if_pkg::FRAME_LEN
) (
  input logic                 clk,
  input logic                 rst_n,
  serial_frame_sched_if.slave bus
);
  import serial_if_pkg::frame_state_t;
  import serial_if_pkg::IDLE_FRM;
  import serial_if_pkg::ACTIVE_FRM;
  import serial_if_pkg::REPORT;
  import serial_if_pkg::SAMPLE_CNT;
  import serial_if_pkg::ACT_END_CNT;
  import serial_if_pkg::cnt_next;

  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TXC_W = $clog2(FRAME_LEN + 1);
  // Markers keep their distance from the frame end when FRAME_LEN changes
  localparam logic [5:0] SMP     = 6'(FRAME_LEN - (serial_if_pkg::FRAME_LEN - SAMPLE_CNT));
  localparam logic [5:0] ACT_END = 6'(FRAME_LEN - (serial_if_pkg::FRAME_LEN - ACT_END_CNT));

  logic [5:0]       cnt_q;
  frame_state_t     state_q, state_d;
  logic [N_REQ-1:0] grant, gnt_q;
  logic [ID_W-1:0]  last;
  logic [CMD_W-1:0] tx_q, cmd_sel;
  logic [TXC_W-1:0] tx_cnt;
  logic [RSP_W-1:0] rx_q;
  logic [3:0]       rx_cnt;
  logic             load, win, tx_shift, rx_shift;
  logic             busy_c, rsp_valid_c, bit_err;

  assign load     = (cnt_q == SMP);
  assign win      = |bus.req;
  assign tx_shift = bus.sr_en & bus.dq_en;
  assign rx_shift = bus.sr_en & ~bus.dq_en;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.req),
    .advance (load),
    .grant   (grant),
    .last    (last)
  );

  always_comb begin
    cmd_sel = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant[i]) cmd_sel = bus.req_cmd[i*CMD_W +: CMD_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_next(cnt_q, FRAME_LEN);
  end

  // No winner leaves grant at zero, so an idle frame loads an empty command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q  <= '0;
      tx_q   <= '0;
      tx_cnt <= '0;
      rx_q   <= '0;
      rx_cnt <= '0;
    end else begin
      gnt_q <= load ? grant : '0;
      if (load) begin
        tx_q   <= cmd_sel;
        tx_cnt <= '0;
      end else if (tx_shift) begin
        tx_q   <= {tx_q[CMD_W-2:0], 1'b0};
        tx_cnt <= tx_cnt + TXC_W'(1);
      end
      if (load) begin
        rx_q   <= '0;
        rx_cnt <= '0;
      end else if (rx_shift) begin
        rx_q <= {rx_q[RSP_W-2:0], bus.dq_in};
        if (rx_cnt != 4'hF) rx_cnt <= rx_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE_FRM;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    busy_c      = 1'b0;
    rsp_valid_c = 1'b0;
    case (state_q)
      IDLE_FRM: if (load && win) state_d = ACTIVE_FRM;
      ACTIVE_FRM: begin
        busy_c = 1'b1;
        if (cnt_q == ACT_END) state_d = REPORT;
      end
      REPORT: begin
        busy_c      = 1'b1;
        rsp_valid_c = 1'b1;
        state_d     = (load && win) ? ACTIVE_FRM : IDLE_FRM;
      end
      default: state_d = IDLE_FRM;
    endcase
  end

  assign bit_err = (int'(tx_cnt) != CMD_W) || (int'(rx_cnt) != RSP_W);

  assign bus.count40   = cnt_q;
  assign bus.gnt       = gnt_q;
  assign bus.dq_out    = tx_q[CMD_W-1];
  assign bus.busy      = busy_c;
  assign bus.rsp_valid = rsp_valid_c;
  // The arbiter's last winner is the owner of the frame being reported
  assign bus.rsp_id    = rsp_valid_c ? last : '0;
  assign bus.rsp_data  = rx_q;
  assign bus.rsp_err   = rsp_valid_c & bit_err;
endmodule

// File: tb/tb_serial_frame_sched.sv
// Bench for serial_frame_sched: a frame table plus hand-written reset,
// single-request bit-sequence and late-request sequences.
module tb_serial_frame_sched;
  localparam int N_REQ = 4, CMD_W = 7, RSP_W = 10, FRAME_LEN = 40;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_frame_sched_if #(.N_REQ(N_REQ), .CMD_W(CMD_W), .RSP_W(RSP_W)) bus ();

  serial_frame_sched #(.N_REQ(N_REQ), .CMD_W(CMD_W), .RSP_W(RSP_W), .FRAME_LEN(FRAME_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { int id; logic [RSP_W-1:0] data; logic err; } rsp_t;
  typedef struct {
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    int               supp;
    logic [RSP_W-1:0] pat;
  } vec_t;

  rsp_t             exp_q[$];
  vec_t             tbl[10];
  int               checks = 0, errors = 0;
  int               supp_c = -1;
  logic [RSP_W-1:0] rsp_pat = '0;
  logic [CMD_W-1:0] dq_seq = 7'b1011001;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int onehot_id(input logic [N_REQ-1:0] oh);
    int r = 0;
    for (int i = 0; i < N_REQ; i++) if (oh[i]) r = i;
    return r;
  endfunction

  // Response as seen on the wire: read cycles 8..17, one cycle optionally lost
  function automatic logic [RSP_W-1:0] exp_rx(input logic [RSP_W-1:0] pat, input int supp);
    logic [RSP_W-1:0] r = '0;
    for (int j = 0; j < RSP_W; j++)
      if (j + 8 != supp) r = {r[RSP_W-2:0], pat[RSP_W-1-j]};
    return r;
  endfunction

  // Interface FSM: write cycles 0..6, read cycles 8..17
  always @(negedge clk) begin
    int c;
    c = int'(bus.count40);
    bus.dq_en = 1'b0;
    bus.sr_en = 1'b0;
    bus.dq_in = 1'b0;
    if (c <= CMD_W - 1) begin
      bus.dq_en = 1'b1;
      bus.sr_en = 1'b1;
    end else if (c >= 8 && c < 8 + RSP_W) begin
      bus.sr_en = (c != supp_c);
      bus.dq_in = rsp_pat[RSP_W-1-(c-8)];
    end
  end

  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      rsp_t e;
      chk("rsp_cycle", 32'(bus.count40), 32'd37);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got id %0d data %0h, expected no response",
                 bus.rsp_id, bus.rsp_data);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_id", 32'(bus.rsp_id), e.id);
        chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
        chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
      end
    end
  end

  task automatic wait_cnt(input int t);
    int n = 0;
    @(negedge clk);
    while (int'(bus.count40) != t && n < 4 * FRAME_LEN) begin
      @(negedge clk);
      n++;
    end
    if (int'(bus.count40) != t) begin
      checks++;
      errors++;
      $display("FAIL wait_cnt: count40 %0d, expected %0d", bus.count40, t);
    end
  endtask

  task automatic run_frame(input vec_t v);
    wait_cnt(FRAME_LEN - 2);
    bus.req = v.req;
    supp_c  = v.supp;
    rsp_pat = v.pat;
    if (v.gnt != '0)
      exp_q.push_back('{onehot_id(v.gnt), exp_rx(v.pat, v.supp),
                        (v.supp >= 8 && v.supp < 8 + RSP_W)});
    wait_cnt(0);
    chk("gnt", 32'(bus.gnt), 32'(v.gnt));
    chk("busy", 32'(bus.busy), 32'(v.gnt != '0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{4'b1111, 4'b0001, -1, 10'h2A5};
    tbl[1] = '{4'b1111, 4'b0010, -1, 10'h15A};
    tbl[2] = '{4'b1111, 4'b0100, -1, 10'h3C3};
    tbl[3] = '{4'b1111, 4'b1000, -1, 10'h00F};
    tbl[4] = '{4'b1111, 4'b0001, -1, 10'h381};
    tbl[5] = '{4'b0000, 4'b0000, -1, 10'h3FF};
    tbl[6] = '{4'b0101, 4'b0100, -1, 10'h123};
    tbl[7] = '{4'b0101, 4'b0001, -1, 10'h2DB};
    tbl[8] = '{4'b0010, 4'b0010, 12, 10'h1E7};
    tbl[9] = '{4'b1000, 4'b1000, -1, 10'h0AA};

    rst_n       = 1'b0;
    bus.req     = '0;
    bus.req_cmd = {7'h4C, 7'h33, 7'h22, 7'h11};
    bus.dq_en   = 1'b0;
    bus.sr_en   = 1'b0;
    bus.dq_in   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_count40", 32'(bus.count40), 0);
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 0);
    chk("rst_dq_out", 32'(bus.dq_out), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_frame(tbl[i]);
      @(negedge clk);
      chk("gnt_pulse", 32'(bus.gnt), 0);
      bus.req = bus.req & ~tbl[i].gnt;
    end

    // Single request: command bits appear MSB first from count40=0
    wait_cnt(FRAME_LEN - 2);
    bus.req              = 4'b0001;
    bus.req_cmd[CMD_W-1:0] = 7'b1011001;
    supp_c               = -1;
    rsp_pat              = 10'b1100110101;
    exp_q.push_back('{0, 10'h335, 1'b0});
    wait_cnt(0);
    chk("single_gnt", 32'(bus.gnt), 32'b0001);
    bus.req = '0;
    for (int k = 0; k < CMD_W; k++) begin
      chk("dq_out_seq", 32'(bus.dq_out), 32'(dq_seq[CMD_W-1-k]));
      @(negedge clk);
    end
    chk("dq_out_drained", 32'(bus.dq_out), 0);

    // Idle frame, then a request rising just after the sampling edge
    wait_cnt(FRAME_LEN - 1);
    @(negedge clk);
    chk("count_wrap", 32'(bus.count40), 0);
    chk("idle_gnt", 32'(bus.gnt), 0);
    chk("idle_busy", 32'(bus.busy), 0);
    bus.req = 4'b0100;
    rsp_pat = 10'h0F3;
    exp_q.push_back('{2, 10'h0F3, 1'b0});
    wait_cnt(FRAME_LEN - 1);
    chk("late_gnt_wait", 32'(bus.gnt), 0);
    chk("late_busy_wait", 32'(bus.busy), 0);
    @(negedge clk);
    chk("late_gnt", 32'(bus.gnt), 32'b0100);
    bus.req = '0;

    // Reset in the middle of an active frame
    wait_cnt(FRAME_LEN - 2);
    bus.req = 4'b0010;
    wait_cnt(0);
    chk("abort_gnt", 32'(bus.gnt), 32'b0010);
    wait_cnt(20);
    chk("abort_busy", 32'(bus.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_count40", 32'(bus.count40), 0);
    chk("abort_busy_rst", 32'(bus.busy), 0);
    chk("abort_gnt_rst", 32'(bus.gnt), 0);
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("abort_rsp_data", 32'(bus.rsp_data), 0);
    chk("abort_dq_out", 32'(bus.dq_out), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_cnt(FRAME_LEN - 2);
    chk("post_rst_no_gnt", 32'(bus.gnt), 0);
    exp_q.push_back('{1, 10'h0F3, 1'b0});
    wait_cnt(0);
    chk("post_rst_gnt", 32'(bus.gnt), 32'b0010);
    bus.req = '0;

    wait_cnt(FRAME_LEN - 1);
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
